// File: rtl/multicycle_ctrl.sv
// Main sequencer for the multicycle core: walks the shared datapath through fetch/decode/execute/memory/writeback,
// owns the memory request handshake with timeout, counts retired instructions and stops on halt or fault.
module multicycle_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  Zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  MemWrite,
  output logic                  AdrSrc,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  RegWrite,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ALUOp,
  output logic [1:0]            ResultSrc,
  output logic                  halted,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  output logic [DATA_WIDTH-1:0] instret
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_LUI, S_ALUWB, S_JAL, S_BRANCH, S_HALT, S_TRAP
  } state_t;

  localparam int WW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  state_t          state, next_state;
  logic [WW-1:0]   wait_cnt;
  logic            set_cause;
  logic [1:0]      cause_d;
  logic            retire;

  // Only funct3[0] selects the branch sense; the other bits are don't-care here.
  logic unused_funct3;
  assign unused_funct3 = ^funct3[2:1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    ResultSrc  = 2'b00;
    halted     = 1'b0;
    trap       = 1'b0;
    set_cause  = 1'b0;
    cause_d    = 2'b00;

    unique case (state)
      S_IDLE: next_state = S_FETCH;

      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          next_state = S_TRAP;
          set_cause  = 1'b1;
          cause_d    = CAUSE_TIMEOUT;
        end
      end

      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        unique case (op)
          7'b0000011, 7'b0100011: next_state = S_MEMADR;
          7'b0110011:             next_state = S_EXECR;
          7'b0010011:             next_state = S_EXECI;
          7'b0110111:             next_state = S_LUI;
          7'b1101111:             next_state = S_JAL;
          7'b1100011:             next_state = S_BRANCH;
          7'b1110011:             next_state = S_HALT;
          default: begin
            next_state = S_TRAP;
            set_cause  = 1'b1;
            cause_d    = CAUSE_ILLEGAL;
          end
        endcase
      end

      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        next_state = op[5] ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) begin
          next_state = S_MEMWB;
        end else if (wait_cnt == WAIT_LAST) begin
          next_state = S_TRAP;
          set_cause  = 1'b1;
          cause_d    = CAUSE_TIMEOUT;
        end
      end

      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end

      S_MEMWR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) begin
          next_state = S_FETCH;
        end else if (wait_cnt == WAIT_LAST) begin
          next_state = S_TRAP;
          set_cause  = 1'b1;
          cause_d    = CAUSE_TIMEOUT;
        end
      end

      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b10;
        next_state = S_ALUWB;
      end

      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUOp      = 2'b10;
        next_state = S_ALUWB;
      end

      S_LUI: begin
        ALUSrcB    = 2'b01;
        ALUOp      = 2'b11;
        next_state = S_ALUWB;
      end

      S_ALUWB: begin
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end

      // PC takes the target computed in DECODE while the ALU forms OldPC+4 for the link.
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCWrite    = 1'b1;
        next_state = S_ALUWB;
      end

      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        PCWrite    = Zero ^ funct3[0];
        next_state = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      S_TRAP: trap = 1'b1;

      default: next_state = S_IDLE;
    endcase
  end

  assign retire = (next_state == S_FETCH) &&
                  ((state == S_MEMWB) || (state == S_MEMWR) ||
                   (state == S_ALUWB) || (state == S_BRANCH));

  // Any state change clears the wait counter, which covers entry into every request state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (next_state != state) begin
      wait_cnt <= '0;
    end else if (mem_req && !mem_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trap_cause <= 2'b00;
    end else if (set_cause) begin
      trap_cause <= cause_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + 1'b1;
    end
  end

endmodule
